memory_arbiter: RTL and testbench

Memory-side responder for the cache/memory request interface. Accepts instruction-fetch requests from the icache and load/store requests from the dcache, arbitrates them onto a single-ported RAM, and returns data with per-port wait handshakes. Sits between the caches block and the RAM model/controller; the caches are the initiators and this block is the responder.

---
 rtl/memory_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Memory-side responder between the icache/dcache request ports and a
// single-ported RAM. One access is in flight at a time. Data requests win over
// instruction requests so the pipeline MEM stage never waits behind IF.
//
// Optional build macro:
//   ARB_FAIRNESS_EN  - bounds instruction starvation: once STARVE_MAX data
//                      grants have been made while iREN waited, the next grant
//                      goes to the instruction port. Undefined: strict data
//                      priority, no counter.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   iREN, iaddr       icache read request (level) and byte address
//   iwait, iload      icache wait (low one cycle on completion), read data
//   dREN, dWEN        dcache read / write request (both high = write)
//   daddr, dstore     dcache byte address and write data
//   dwait, dload      dcache wait (low one cycle on completion), read data
//   ramREN, ramWEN    RAM read / write strobes (never both high)
//   ramaddr, ramstore RAM address / write data, driven from latched values
//   ramload, ram_ack  RAM read data, valid when ram_ack completes the access
//
// Timing: request seen in IDLE at cycle n -> strobe from n+1; ram_ack at
// n+1+k -> wait low at n+2+k. Minimum access period is 3 cycles.
// -----------------------------------------------------------------------------
module memory_arbiter #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   // instruction port
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   // data port
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   // RAM side
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ram_ack
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IACC  = 3'd1,
      DACC  = 3'd2,
      IRESP = 3'd3,
      DRESP = 3'd4
   } state_t;

   state_t            state, state_nxt;

   // Access captured at grant; the RAM only ever sees these registers, so
   // requester inputs may change freely while the access is in flight.
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              wr_q;
   // Requester still asking for this access. Cleared if the request drops at
   // any point during the RAM phase so no completion is reported to it.
   logic              live_q;

   logic              dreq;
   logic              grant_i;
   logic              grant_d;
   logic              starved;

   assign dreq = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_q;

   assign starved = (starve_q == CNT_W'(STARVE_MAX));

   // Counts data grants made while an instruction fetch was waiting. It never
   // passes STARVE_MAX: at that value a waiting fetch takes the next grant.
   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_q <= '0;
      end else if (grant_i) begin
         starve_q <= '0;
      end else if (grant_d) begin
         if (iREN) starve_q <= starve_q + 1'b1;
         else      starve_q <= '0;
      end
   end
`else
   assign starved = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state / grant logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (iREN && starved) begin
               grant_i   = 1'b1;
               state_nxt = IACC;
            end else if (dreq) begin
               grant_d   = 1'b1;
               state_nxt = DACC;
            end else if (iREN) begin
               grant_i   = 1'b1;
               state_nxt = IACC;
            end
         end
         IACC:    if (ram_ack) state_nxt = IRESP;
         DACC:    if (ram_ack) state_nxt = DRESP;
         IRESP:   state_nxt = IDLE;
         DRESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs, decoded from registered state only
   // ---------------------------------------------------------------------------
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramaddr  = addr_q;
      ramstore = wdata_q;
      case (state)
         IACC:    ramREN = 1'b1;
         DACC: begin
            ramREN = ~wr_q;
            ramWEN = wr_q;
         end
         IRESP:   iwait  = ~live_q;
         DRESP:   dwait  = ~live_q;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, latched access and load registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         live_q  <= 1'b0;
         iload   <= '0;
         dload   <= '0;
      end else begin
         state <= state_nxt;

         if (grant_i) begin
            addr_q <= iaddr;
            wr_q   <= 1'b0;
            live_q <= 1'b1;
         end else if (grant_d) begin
            addr_q  <= daddr;
            wdata_q <= dstore;
            wr_q    <= dWEN;        // dREN & dWEN together is a write
            live_q  <= 1'b1;
         end

         // Withdrawal: the RAM access still runs to ram_ack (a write must not
         // be torn), only the completion report is suppressed.
         if (state == IACC && !iREN) live_q <= 1'b0;
         if (state == DACC && !dreq) live_q <= 1'b0;

         if (state == IACC && ram_ack)          iload <= ramload;
         if (state == DACC && ram_ack && !wr_q) dload <= ramload;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Bench for memory_arbiter. A small RAM model with programmable ack latency
// sits on the RAM side. Expected completions are queued per port when a
// request is driven and checked when the matching wait goes low.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ack;

   memory_arbiter #(.WORD_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ram_ack(ram_ack)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        iq[$];
   exp_t        dq[$];
   int          checks = 0;
   int          errors = 0;
   bit          sb_en  = 1'b0;
   int          lat    = 0;
   int          ack_cnt = 0;
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- RAM model: ack after 'lat' extra strobe cycles ----------
   always @* ram_ack = (ramREN | ramWEN) && (ack_cnt == lat);
   always @* ramload = mem[ramaddr[9:2]];

   always @(posedge CLK) begin
      if ((ramREN | ramWEN) && !ram_ack) ack_cnt <= ack_cnt + 1;
      else                               ack_cnt <= 0;
      if (ramWEN && ram_ack) mem[ramaddr[9:2]] <= ramstore;
   end

   // ---------------- scoreboard monitor --------------------------------------
   always @(negedge CLK) begin : mon
      exp_t e;
      if (sb_en && !RST) begin
         if (!iwait) begin
            chk("iq_pending", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
               e = iq.pop_front();
               chk("iload", iload, e.data);
            end
         end
         if (!dwait) begin
            chk("dq_pending", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
               e = dq.pop_front();
               if (e.wr) chk("ram_written", mem[e.addr[9:2]], e.data);
               else      chk("dload", dload, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input bit port_i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data);
      exp_t e;
      e.wr   = wr;
      e.addr = addr;
      if (wr) begin
         ref_mem[addr[9:2]] = data;
         e.data = data;
      end else begin
         e.data = ref_mem[addr[9:2]];
      end
      if (port_i) iq.push_back(e);
      else        dq.push_back(e);
   endtask

   task automatic drive(input bit port_i, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data);
      if (port_i) begin
         iREN  = 1'b1;
         iaddr = addr;
      end else begin
         dWEN   = wr;
         dREN   = ~wr;
         daddr  = addr;
         dstore = data;
      end
   endtask

   // Full handshake on one port; the monitor checks the returned data.
   task automatic do_access(input bit port_i, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input int l);
      bit done = 1'b0;
      lat = l;
      push(port_i, wr, addr, data);
      drive(port_i, wr, addr, data);
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (port_i && !iwait) begin
            iREN = 1'b0;
            done = 1'b1;
         end else if (!port_i && !dwait) begin
            dREN = 1'b0;
            dWEN = 1'b0;
            done = 1'b1;
         end
      end
      chk("access_done", 32'(done), 32'd1);
      tick();
   endtask

   initial begin
      int dt, it, lows, nd;
      bit iserved;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = ~(32'(i) << 2);
         ref_mem[i] = ~(32'(i) << 2);
      end
      mem[32'h40 >> 2]     = 32'h8C22_0004;
      ref_mem[32'h40 >> 2] = 32'h8C22_0004;

      RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
      daddr = '0; dstore = '0;

      // ---------------- reset ----------------
      tick(); tick();
      chk("rst_iwait",    32'(iwait),  32'd1);
      chk("rst_dwait",    32'(dwait),  32'd1);
      chk("rst_ramREN",   32'(ramREN), 32'd0);
      chk("rst_ramWEN",   32'(ramWEN), 32'd0);
      chk("rst_iload",    iload,       32'd0);
      chk("rst_dload",    dload,       32'd0);
      chk("rst_ramaddr",  ramaddr,     32'd0);
      chk("rst_ramstore", ramstore,    32'd0);
      RST   = 1'b0;
      sb_en = 1'b1;

      // ---------------- instruction fetch, ack in first strobe cycle -------
      lat = 0;
      push(1'b1, 1'b0, 32'h40, 32'h0);
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      chk("if_c0_ramREN", 32'(ramREN), 32'd0);
      tick();
      chk("if_c1_ramREN",  32'(ramREN), 32'd1);
      chk("if_c1_ramaddr", ramaddr,     32'h40);
      chk("if_c1_iwait",   32'(iwait),  32'd1);
      tick();
      chk("if_c2_iwait",  32'(iwait),  32'd0);
      chk("if_c2_iload",  iload,       32'h8C22_0004);
      chk("if_c2_ramREN", 32'(ramREN), 32'd0);
      iREN = 1'b0;
      tick();
      chk("if_c3_iwait", 32'(iwait), 32'd1);
      tick();

      // ---------------- store with 3-cycle RAM ----------------
      lat = 2;
      push(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
      drive(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("st_ramWEN",   32'(ramWEN), 32'd1);
         chk("st_ramREN",   32'(ramREN), 32'd0);
         chk("st_ramaddr",  ramaddr,     32'h100);
         chk("st_ramstore", ramstore,    32'hDEAD_BEEF);
         chk("st_dwait",    32'(dwait),  32'd1);
         chk("st_iwait",    32'(iwait),  32'd1);
      end
      tick();
      chk("st_dwait_low", 32'(dwait),  32'd0);
      chk("st_ramWEN_lo", 32'(ramWEN), 32'd0);
      chk("st_iwait_hi",  32'(iwait),  32'd1);
      dWEN = 1'b0;
      tick();
      chk("st_dwait_hi", 32'(dwait), 32'd1);

      // ---------------- contention: data first ----------------
      lat = 1; dt = -1; it = -1;
      push(1'b0, 1'b0, 32'h200, 32'h0);
      push(1'b1, 1'b0, 32'h44,  32'h0);
      drive(1'b0, 1'b0, 32'h200, 32'h0);
      drive(1'b1, 1'b0, 32'h44,  32'h0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (!dwait && dt < 0) begin dt = c; dREN = 1'b0; end
         if (!iwait && it < 0) begin it = c; iREN = 1'b0; end
      end
      chk("cont_dwait_cycle", 32'(dt), 32'd3);
      chk("cont_iwait_cycle", 32'(it), 32'd7);

      // ---------------- withdrawal during DACC ----------------
      lat = 2; lows = 0;
      drive(1'b0, 1'b0, 32'h104, 32'h0);
      tick();
      chk("wd_c1_ramREN", 32'(ramREN), 32'd1);
      dREN = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         tick();
         if (!dwait) lows++;
         if (c == 3) chk("wd_c3_ramREN", 32'(ramREN), 32'd1);
         if (c == 4) chk("wd_c4_ramREN", 32'(ramREN), 32'd0);
      end
      chk("wd_dwait_lows", 32'(lows), 32'd0);
      do_access(1'b1, 1'b0, 32'h48, 32'h0, 1);

      // ---------------- reset mid-access ----------------
      lat = 7;
      drive(1'b0, 1'b1, 32'h3F0, 32'h1234_5678);
      tick(); tick();
      chk("rma_ramWEN_pre", 32'(ramWEN), 32'd1);
      RST = 1'b1; dWEN = 1'b0;
      tick();
      chk("rma_ramWEN", 32'(ramWEN), 32'd0);
      chk("rma_dwait",  32'(dwait),  32'd1);
      chk("rma_ramaddr", ramaddr,    32'd0);
      RST = 1'b0;
      tick();
      chk("rma_dwait_after", 32'(dwait), 32'd1);

      // ---------------- random mix through the scoreboard ----------------
      for (int n = 0; n < 12; n++) begin
         bit          p  = 1'($urandom_range(0, 1));
         bit          w  = p ? 1'b0 : 1'($urandom_range(0, 1));
         logic [31:0] a  = 32'h100 + 32'(4 * $urandom_range(0, 3));
         do_access(p, w, a, $urandom, int'($urandom_range(0, 3)));
      end

      // ---------------- starvation ----------------
      sb_en = 1'b0; lat = 0; nd = 0; iserved = 1'b0;
      drive(1'b0, 1'b0, 32'h108, 32'h0);
      drive(1'b1, 1'b0, 32'h4C,  32'h0);
      for (int c = 0; c < 40 && !iserved; c++) begin
         tick();
         if (!dwait) nd++;
         if (!iwait) iserved = 1'b1;
      end
`ifdef ARB_FAIRNESS_EN
      chk("starve_iserved", 32'(iserved), 32'd1);
      chk("starve_dgrants", 32'(nd),      32'd4);
`else
      chk("starve_iserved",  32'(iserved), 32'd0);
      chk("strict_dgrants",  32'(nd >= 12), 32'd1);
`endif
      dREN = 1'b0; iREN = 1'b0;
      tick(); tick(); tick();

      chk("iq_drained", 32'(iq.size()), 32'd0);
      chk("dq_drained", 32'(dq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
